pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/mips_pkg.sv | 19 +
 rtl/pc_sequencer.sv | 94 +++++++++
 tb/tb_pc_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared constants and types for the instruction-fetch front end.
//   RESET_VECTOR  : first fetch address after reset
//   HALT_ADDR     : redirect target that stops the CPU
//   INSTR_BYTES   : size of one instruction in bytes
//   pcseq_state_t : PC sequencer states (sequential, delay slot, halted)
package mips_pkg;

   localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
   localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;
   localparam logic [31:0] INSTR_BYTES  = 32'd4;

   typedef enum logic [1:0] {
      SEQ  = 2'd0,
      SLOT = 2'd1,
      HALT = 2'd2
   } pcseq_state_t;

endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Generates instruction fetch addresses for a MIPS-style core with one
// branch delay slot. An accepted redirect fetches the delay slot first
// and reaches the branch target on the following unstalled cycle. A
// redirect to address 0 halts the CPU; a misaligned target halts it with
// a sticky error.
// Ports:
//   clk         : rising-edge clock
//   reset       : synchronous active-high reset
//   stall       : freeze all state this cycle
//   redirect    : taken branch/jump, honoured only in SEQ
//   target      : redirect byte address, latched when redirect is accepted
//   addr        : registered fetch byte address
//   fetch_valid : addr is a real fetch request
//   delay_slot  : instruction at addr is a branch delay slot
//   active      : CPU running
//   err         : halted on a misaligned redirect target (sticky)
module pc_sequencer
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] target,
   output logic [31:0] addr,
   output logic        fetch_valid,
   output logic        delay_slot,
   output logic        active,
   output logic        err
);

   pcseq_state_t state;
   logic [31:0]  pending;

   // All outputs are computed alongside the next state so they come
   // straight from flops, with no combinational path from any input.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= SEQ;
         addr        <= RESET_VECTOR;
         pending     <= HALT_ADDR;
         fetch_valid <= 1'b1;
         delay_slot  <= 1'b0;
         active      <= 1'b1;
         err         <= 1'b0;
      end else if (!stall) begin
         unique case (state)
            SEQ: begin
               // Wraps modulo 2^32; wrap-around never halts.
               addr <= addr + INSTR_BYTES;
               if (redirect) begin
                  pending    <= target;
                  state      <= SLOT;
                  delay_slot <= 1'b1;
               end
            end

            SLOT: begin
               // A redirect seen here is a branch in a delay slot and is
               // deliberately dropped.
               delay_slot <= 1'b0;
               if (pending[1:0] != 2'b00) begin
                  state       <= HALT;
                  err         <= 1'b1;
                  fetch_valid <= 1'b0;
                  active      <= 1'b0;
               end else if (pending == HALT_ADDR) begin
                  state       <= HALT;
                  fetch_valid <= 1'b0;
                  active      <= 1'b0;
               end else begin
                  addr  <= pending;
                  state <= SEQ;
               end
            end

            HALT: begin
               // Terminal until reset; addr keeps the last fetch address.
            end

            default: begin
               state       <= HALT;
               fetch_valid <= 1'b0;
               delay_slot  <= 1'b0;
               active      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Self-checking bench for pc_sequencer: a table of per-cycle vectors
// {reset, stall, redirect, target -> expected outputs after the edge},
// followed by a hand-written halt sequence with randomised inputs.
module tb_pc_sequencer;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] target;
   logic [31:0] addr;
   logic        fetch_valid;
   logic        delay_slot;
   logic        active;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        rst;
      logic        stl;
      logic        rdr;
      logic [31:0] tgt;
      logic [31:0] e_addr;
      logic        e_fv;
      logic        e_ds;
      logic        e_act;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   pc_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .target      (target),
      .addr        (addr),
      .fetch_valid (fetch_valid),
      .delay_slot  (delay_slot),
      .active      (active),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Drive inputs, let one rising edge pass, then sample 1 ns later.
   task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
      reset    = r;
      stall    = s;
      redirect = d;
      target   = t;
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [31:0] ea, input logic efv,
                             input logic eds, input logic eact, input logic eerr);
      check({tag, ".addr"}, addr, ea);
      check({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, efv});
      check({tag, ".delay_slot"}, {31'd0, delay_slot}, {31'd0, eds});
      check({tag, ".active"}, {31'd0, active}, {31'd0, eact});
      check({tag, ".err"}, {31'd0, err}, {31'd0, eerr});
   endtask

   task automatic add(input logic r, input logic s, input logic d, input logic [31:0] t,
                      input logic [31:0] ea, input logic efv, input logic eds,
                      input logic eact, input logic eerr);
      vec_t v;
      v.rst = r; v.stl = s; v.rdr = d; v.tgt = t;
      v.e_addr = ea; v.e_fv = efv; v.e_ds = eds; v.e_act = eact; v.e_err = eerr;
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] held;

      reset = 1'b1; stall = 1'b0; redirect = 1'b0; target = 32'h0;

      //  rst stl rdr target         addr          fv ds act err
      // Reset and sequential fetch
      add(1, 0, 0, 32'h0,          32'hBFC0_0000, 1, 0, 1, 0);
      add(0, 0, 0, 32'h0,          32'hBFC0_0004, 1, 0, 1, 0);
      add(0, 0, 0, 32'h0,          32'hBFC0_0008, 1, 0, 1, 0);
      add(0, 0, 0, 32'h0,          32'hBFC0_000C, 1, 0, 1, 0);
      // Plain redirect from BFC00004
      add(1, 0, 0, 32'h0,          32'hBFC0_0000, 1, 0, 1, 0);
      add(0, 0, 0, 32'h0,          32'hBFC0_0004, 1, 0, 1, 0);
      add(0, 0, 1, 32'hBFC0_0100,  32'hBFC0_0008, 1, 1, 1, 0);
      add(0, 0, 0, 32'h0,          32'hBFC0_0100, 1, 0, 1, 0);
      add(0, 0, 0, 32'h0,          32'hBFC0_0104, 1, 0, 1, 0);
      // Stall in SLOT with redirect toggling; the original target wins
      add(0, 0, 1, 32'hBFC0_0200,  32'hBFC0_0108, 1, 1, 1, 0);
      add(0, 1, 1, 32'hDEAD_0000,  32'hBFC0_0108, 1, 1, 1, 0);
      add(0, 1, 0, 32'h0,          32'hBFC0_0108, 1, 1, 1, 0);
      add(0, 1, 1, 32'h1234_5678,  32'hBFC0_0108, 1, 1, 1, 0);
      add(0, 0, 1, 32'hCAFE_0000,  32'hBFC0_0200, 1, 0, 1, 0);
      add(0, 0, 0, 32'h0,          32'hBFC0_0204, 1, 0, 1, 0);
      // Stall in SEQ ignores redirect
      add(0, 1, 1, 32'h0000_0040,  32'hBFC0_0204, 1, 0, 1, 0);
      add(0, 0, 0, 32'h0,          32'hBFC0_0208, 1, 0, 1, 0);
      // Wrap-around through FFFFFFFC is not a halt
      add(0, 0, 1, 32'hFFFF_FFFC,  32'hBFC0_020C, 1, 1, 1, 0);
      add(0, 0, 0, 32'h0,          32'hFFFF_FFFC, 1, 0, 1, 0);
      add(0, 0, 0, 32'h0,          32'h0000_0000, 1, 0, 1, 0);
      add(0, 0, 0, 32'h0,          32'h0000_0004, 1, 0, 1, 0);
      // Reset during SLOT discards the pending target
      add(0, 0, 1, 32'h0000_1000,  32'h0000_0008, 1, 1, 1, 0);
      add(1, 0, 0, 32'h0,          32'hBFC0_0000, 1, 0, 1, 0);
      add(0, 0, 0, 32'h0,          32'hBFC0_0004, 1, 0, 1, 0);
      add(0, 0, 0, 32'h0,          32'hBFC0_0008, 1, 0, 1, 0);
      // Misaligned target -> error halt, inputs ignored, reset beats stall
      add(0, 0, 1, 32'hBFC0_0102,  32'hBFC0_000C, 1, 1, 1, 0);
      add(0, 0, 0, 32'h0,          32'hBFC0_000C, 0, 0, 0, 1);
      add(0, 0, 1, 32'h0000_0100,  32'hBFC0_000C, 0, 0, 0, 1);
      add(1, 1, 1, 32'h0000_0200,  32'hBFC0_0000, 1, 0, 1, 0);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].stl, vecs[i].rdr, vecs[i].tgt);
         check_outs($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_fv,
                    vecs[i].e_ds, vecs[i].e_act, vecs[i].e_err);
      end

      // Halt via redirect to 0: one delay-slot fetch, then frozen
      step(0, 0, 1, 32'h0);
      check_outs("halt.slot", 32'hBFC0_0004, 1, 1, 1, 0);
      step(0, 0, 0, 32'h0);
      check_outs("halt.enter", 32'hBFC0_0004, 0, 0, 0, 0);
      held = 32'hBFC0_0004;
      for (int k = 0; k < 12; k++) begin
         step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom());
         check_outs($sformatf("halt.hold%0d", k), held, 0, 0, 0, 0);
      end

      // Reset from HALT, with redirect asserted, restarts at the vector
      step(1, 0, 1, 32'h0000_0400);
      check_outs("halt.reset", 32'hBFC0_0000, 1, 0, 1, 0);
      step(0, 0, 0, 32'h0);
      check_outs("halt.resume", 32'hBFC0_0004, 1, 0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
